// File: rtl/clk_pkg.sv
// Shared bounds and widths for the clock datapath fields.
// Instances pick their MIN/MAX/WIDTH from these constants.
package clk_pkg;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HR24_MAX = 23;
    localparam int HR12_MIN = 1;
    localparam int HR12_MAX = 12;

    localparam int SEC_W = 6;
    localparam int HR_W  = 5;

endpackage

// File: rtl/counter_updown_mod_if.sv
// Control and status bundle of one up/down modulo counter stage.
// master drives the requests, slave is the counter itself.
interface counter_updown_mod_if #(
    parameter int WIDTH = 10
);

    logic             i_en;
    logic             i_up;
    logic             i_down;
    logic             i_load;
    logic [WIDTH-1:0] i_load_val;
    logic [WIDTH-1:0] o_count;
    logic             o_carryup;
    logic             o_borrowdown;
    logic             o_at_max;
    logic             o_at_min;

    modport master (
        output i_en, i_up, i_down, i_load, i_load_val,
        input  o_count, o_carryup, o_borrowdown,
        input  o_at_max, o_at_min
    );

    modport slave (
        input  i_en, i_up, i_down, i_load, i_load_val,
        output o_count, o_carryup, o_borrowdown,
        output o_at_max, o_at_min
    );

endinterface

// File: rtl/counter_updown_mod.sv
// Single-stage up/down counter over [MIN..MAX], wrap or saturate.
// Carry/borrow are combinational so stages chain on the same edge.
module counter_updown_mod
    import clk_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int MIN      = 0,
    parameter int MAX      = 999,
    parameter int RST_VAL  = 0,
    parameter int SATURATE = 0
) (
    input logic                 i_clk,
    input logic                 i_rstn,
    counter_updown_mod_if.slave bus
);

    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);
    localparam bit               SAT   = (SATURATE != 0);

    if (MIN >= MAX) begin : g_bad_range
        $fatal(1, "counter_updown_mod: MIN must be below MAX");
    end
    if (longint'(MAX) >= (longint'(1) << WIDTH)) begin : g_bad_width
        $fatal(1, "counter_updown_mod: MAX does not fit WIDTH");
    end
    if (RST_VAL < MIN || RST_VAL > MAX) begin : g_bad_rst
        $fatal(1, "counter_updown_mod: RST_VAL outside range");
    end
    if ($bits(bus.o_count) != WIDTH) begin : g_bad_bus
        $fatal(1, "counter_updown_mod: bus width mismatch");
    end

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] load_clamped;
    logic             step_up;
    logic             step_dn;
    logic             at_max;
    logic             at_min;
    logic             in_range;

    assign step_up  = bus.i_en & bus.i_up & ~bus.i_down;
    assign step_dn  = bus.i_en & bus.i_down & ~bus.i_up;
    assign at_max   = (count == MAX_V);
    assign at_min   = (count == MIN_V);
    assign in_range = (count >= MIN_V) && (count <= MAX_V);

    assign load_clamped =
        (bus.i_load_val > MAX_V) ? MAX_V :
        (bus.i_load_val < MIN_V) ? MIN_V :
        bus.i_load_val;

    // Count register: reset > load > step > hold.
    // A corrupted out-of-range count recovers to MIN on the next step.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            count <= RST_V;
        end else if (bus.i_load) begin
            count <= load_clamped;
        end else if (step_up) begin
            if (!in_range)   count <= MIN_V;
            else if (at_max) count <= SAT ? count : MIN_V;
            else             count <= count + 1'b1;
        end else if (step_dn) begin
            if (!in_range)   count <= MIN_V;
            else if (at_min) count <= SAT ? count : MAX_V;
            else             count <= count - 1'b1;
        end
    end

    assign bus.o_count      = count;
    assign bus.o_at_max     = at_max;
    assign bus.o_at_min     = at_min;
    assign bus.o_carryup    = i_rstn & ~SAT & ~bus.i_load
                            & step_up & at_max;
    assign bus.o_borrowdown = i_rstn & ~SAT & ~bus.i_load
                            & step_dn & at_min;

endmodule
